// File: rtl/axis_bram_streamer.sv
// Replays a BRAM address window onto an AXI4-Stream master once, N times or continuously.
// Optional `m_axis_tuser` start-of-pass marker is enabled with AXIS_BRAM_STREAMER_TUSER_EN.
module axis_bram_streamer #(
    parameter int AXIS_TDATA_WIDTH = 32,
    parameter int BRAM_DATA_WIDTH  = 32,
    parameter int BRAM_ADDR_WIDTH  = 14,
    parameter int BRAM_LATENCY     = 1,
    parameter int CNTR_WIDTH       = 16
) (
    input  logic                        aclk,
    input  logic                        aresetn,
    input  logic                        cfg_enbl,
    input  logic [BRAM_ADDR_WIDTH-1:0]  cfg_start,
    input  logic [BRAM_ADDR_WIDTH-1:0]  cfg_last,
    input  logic [CNTR_WIDTH-1:0]       cfg_reps,
    output logic [BRAM_ADDR_WIDTH-1:0]  sts_addr,
    output logic [CNTR_WIDTH-1:0]       sts_pass,
    output logic                        sts_done,
    input  logic                        m_axis_tready,
    output logic [AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
    output logic                        m_axis_tvalid,
    output logic                        m_axis_tlast,
`ifdef AXIS_BRAM_STREAMER_TUSER_EN
    output logic                        m_axis_tuser,
`endif
    output logic                        bram_porta_clk,
    output logic                        bram_porta_rst,
    output logic [BRAM_ADDR_WIDTH-1:0]  bram_porta_addr,
    input  logic [BRAM_DATA_WIDTH-1:0]  bram_porta_rddata,
    output logic                        bram_porta_we
);

    localparam int FIFO_DEPTH = BRAM_LATENCY + 2;
    localparam int PTR_W      = $clog2(FIFO_DEPTH);
    localparam int CNT_W      = $clog2(FIFO_DEPTH + 1);
`ifdef AXIS_BRAM_STREAMER_TUSER_EN
    localparam int TAG_W = 2;  // {user, last}
`else
    localparam int TAG_W = 1;  // {last}
`endif

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN, ST_DONE} state_t;

    state_t                     state_q, state_d;
    logic [BRAM_ADDR_WIDTH-1:0] addr_q, addr_d, start_q, start_d, last_q, last_d;
    logic [CNTR_WIDTH-1:0]      pass_q, pass_d, reps_q, reps_d;
    logic [BRAM_LATENCY-1:0]    vld_pipe_q, vld_pipe_d;
    logic [BRAM_LATENCY-1:0][TAG_W-1:0] tag_pipe_q, tag_pipe_d;
    logic [PTR_W-1:0]           wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]           count_q, count_d;
    logic [AXIS_TDATA_WIDTH-1:0] fifo_data_q [FIFO_DEPTH];
    logic [AXIS_TDATA_WIDTH-1:0] fifo_data_d [FIFO_DEPTH];
    logic [TAG_W-1:0]           fifo_tag_q [FIFO_DEPTH];
    logic [TAG_W-1:0]           fifo_tag_d [FIFO_DEPTH];

    logic [CNT_W:0]   inflight, occupancy;
    logic             issue, push, pop;
    logic [TAG_W-1:0] issue_tag;

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        pass_d   = pass_q;
        start_d  = start_q;
        last_d   = last_q;
        reps_d   = reps_q;
        issue    = 1'b0;
        inflight = '0;
        for (int i = 0; i < BRAM_LATENCY; i++)
            inflight = inflight + (CNT_W+1)'(vld_pipe_q[i]);
        // Reserve a FIFO slot for every read still in the BRAM pipe so no word can be dropped.
        occupancy = {1'b0, count_q} + inflight;
`ifdef AXIS_BRAM_STREAMER_TUSER_EN
        issue_tag = {addr_q == start_q, addr_q == last_q};
`else
        issue_tag = addr_q == last_q;
`endif
        case (state_q)
            ST_IDLE: if (cfg_enbl) begin
                start_d = cfg_start;
                last_d  = cfg_last;
                reps_d  = cfg_reps;
                addr_d  = cfg_start;
                pass_d  = '0;
                state_d = (cfg_start > cfg_last) ? ST_DONE : ST_RUN;
            end
            ST_RUN: begin
                if (!cfg_enbl) begin
                    state_d = ST_DRAIN;
                end else if (occupancy < (CNT_W+1)'(FIFO_DEPTH)) begin
                    issue = 1'b1;
                    if (addr_q == last_q) begin
                        pass_d = (pass_q == '1) ? pass_q : pass_q + CNTR_WIDTH'(1);
                        if (reps_q == '0 ||
                            ({1'b0, pass_q} + (CNTR_WIDTH+1)'(1)) < {1'b0, reps_q})
                            addr_d = start_q;
                        else
                            state_d = ST_DRAIN;
                    end else begin
                        addr_d = addr_q + BRAM_ADDR_WIDTH'(1);
                    end
                end
            end
            ST_DRAIN: if (vld_pipe_q == '0 && count_q == '0) state_d = ST_DONE;
            ST_DONE:  if (!cfg_enbl) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Read-tag pipe aligned with the BRAM read latency, then the output FIFO.
    always_comb begin
        vld_pipe_d    = vld_pipe_q;
        tag_pipe_d    = tag_pipe_q;
        vld_pipe_d[0] = issue;
        tag_pipe_d[0] = issue_tag;
        for (int i = 1; i < BRAM_LATENCY; i++) begin
            vld_pipe_d[i] = vld_pipe_q[i-1];
            tag_pipe_d[i] = tag_pipe_q[i-1];
        end

        push       = vld_pipe_q[BRAM_LATENCY-1];
        pop        = (count_q != '0) && m_axis_tready;
        fifo_data_d = fifo_data_q;
        fifo_tag_d  = fifo_tag_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        if (push) begin
            fifo_data_d[wr_ptr_q] = AXIS_TDATA_WIDTH'(bram_porta_rddata);
            fifo_tag_d[wr_ptr_q]  = tag_pipe_q[BRAM_LATENCY-1];
            wr_ptr_d = (wr_ptr_q == PTR_W'(FIFO_DEPTH-1)) ? '0 : wr_ptr_q + PTR_W'(1);
        end
        if (pop)
            rd_ptr_d = (rd_ptr_q == PTR_W'(FIFO_DEPTH-1)) ? '0 : rd_ptr_q + PTR_W'(1);
        count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            pass_q     <= '0;
            start_q    <= '0;
            last_q     <= '0;
            reps_q     <= '0;
            vld_pipe_q <= '0;
            tag_pipe_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            pass_q     <= pass_d;
            start_q    <= start_d;
            last_q     <= last_d;
            reps_q     <= reps_d;
            vld_pipe_q <= vld_pipe_d;
            tag_pipe_q <= tag_pipe_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
        end
    end

    always_ff @(posedge aclk) begin
        fifo_data_q <= fifo_data_d;
        fifo_tag_q  <= fifo_tag_d;
    end

    assign m_axis_tvalid = count_q != '0;
    assign m_axis_tdata  = fifo_data_q[rd_ptr_q];
    assign m_axis_tlast  = m_axis_tvalid & fifo_tag_q[rd_ptr_q][0];
`ifdef AXIS_BRAM_STREAMER_TUSER_EN
    assign m_axis_tuser  = m_axis_tvalid & fifo_tag_q[rd_ptr_q][1];
`endif
    assign sts_addr        = addr_q;
    assign sts_pass        = pass_q;
    assign sts_done        = state_q == ST_DONE;
    assign bram_porta_clk  = aclk;
    assign bram_porta_rst  = ~aresetn;
    assign bram_porta_addr = addr_q;
    assign bram_porta_we   = 1'b0;

endmodule

// File: tb/tb_axis_bram_streamer.sv
// Bench: two streamers (BRAM latency 1 and 3) share config/tready; each output stream is
// checked against a queue of words the window/repeat rules say must appear, in order.
module tb_axis_bram_streamer;
    localparam int AW = 14;
    localparam int DW = 32;
    localparam int CW = 16;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
        logic          user;
    } exp_t;

    logic          aclk = 1'b0;
    logic          aresetn = 1'b0;
    logic          cfg_enbl = 1'b0;
    logic [AW-1:0] cfg_start = '0, cfg_last = '0;
    logic [CW-1:0] cfg_reps = '0;
    logic          tready = 1'b0;
    int            ready_mode = 0;  // 0 low, 1 high, 2 random

    logic [AW-1:0] sts_addr_w [2];
    logic [AW-1:0] baddr_w [2];
    logic [CW-1:0] sts_pass_w [2];
    logic [DW-1:0] tdata_w [2];
    logic          sts_done_w [2], tvalid_w [2], tlast_w [2], tuser_w [2];
    logic          bclk_w [2], brst_w [2], we_w [2];
    logic [DW-1:0] rd_l1;
    logic [DW-1:0] rd_l3 [3];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    exp_t exp_q [2][$];
    int   rcv [2];
    int   xcyc [2][1024];

    always #5 aclk = ~aclk;
    always @(posedge aclk) cyc <= cyc + 1;

    function automatic logic [DW-1:0] bram_word(input logic [AW-1:0] a);
        return {4'hA, a, a};
    endfunction

    // BRAM models: registered reads, 1 and 3 edges deep.
    always @(posedge aclk) begin
        rd_l1    <= bram_word(baddr_w[0]);
        rd_l3[0] <= bram_word(baddr_w[1]);
        rd_l3[1] <= rd_l3[0];
        rd_l3[2] <= rd_l3[1];
    end

    always @(posedge aclk) begin
        #1;
        case (ready_mode)
            0:       tready = 1'b0;
            1:       tready = 1'b1;
            default: tready = 1'($urandom_range(0, 1));
        endcase
    end

    axis_bram_streamer #(.BRAM_LATENCY(1)) u_dut1 (
        .aclk(aclk), .aresetn(aresetn), .cfg_enbl(cfg_enbl), .cfg_start(cfg_start),
        .cfg_last(cfg_last), .cfg_reps(cfg_reps), .sts_addr(sts_addr_w[0]),
        .sts_pass(sts_pass_w[0]), .sts_done(sts_done_w[0]), .m_axis_tready(tready),
        .m_axis_tdata(tdata_w[0]), .m_axis_tvalid(tvalid_w[0]), .m_axis_tlast(tlast_w[0]),
`ifdef AXIS_BRAM_STREAMER_TUSER_EN
        .m_axis_tuser(tuser_w[0]),
`endif
        .bram_porta_clk(bclk_w[0]), .bram_porta_rst(brst_w[0]), .bram_porta_addr(baddr_w[0]),
        .bram_porta_rddata(rd_l1), .bram_porta_we(we_w[0])
    );

    axis_bram_streamer #(.BRAM_LATENCY(3)) u_dut3 (
        .aclk(aclk), .aresetn(aresetn), .cfg_enbl(cfg_enbl), .cfg_start(cfg_start),
        .cfg_last(cfg_last), .cfg_reps(cfg_reps), .sts_addr(sts_addr_w[1]),
        .sts_pass(sts_pass_w[1]), .sts_done(sts_done_w[1]), .m_axis_tready(tready),
        .m_axis_tdata(tdata_w[1]), .m_axis_tvalid(tvalid_w[1]), .m_axis_tlast(tlast_w[1]),
`ifdef AXIS_BRAM_STREAMER_TUSER_EN
        .m_axis_tuser(tuser_w[1]),
`endif
        .bram_porta_clk(bclk_w[1]), .bram_porta_rst(brst_w[1]), .bram_porta_addr(baddr_w[1]),
        .bram_porta_rddata(rd_l3[2]), .bram_porta_we(we_w[1])
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Stream monitor: every transfer must be the next model word; stalled words must hold.
    bit            prev_stall [2];
    logic [DW-1:0] prev_data [2];
    logic          prev_last [2], prev_user [2];
    initial begin
        rcv[0] = 0;
        rcv[1] = 0;
        forever begin
            @(negedge aclk);
            for (int i = 0; i < 2; i++) begin
                if (!aresetn) begin
                    prev_stall[i] = 1'b0;
                end else begin
                    if (prev_stall[i]) begin
                        chk($sformatf("hold_valid[%0d]", i), tvalid_w[i], 1);
                        chk($sformatf("hold_data[%0d]", i), tdata_w[i], prev_data[i]);
                        chk($sformatf("hold_last[%0d]", i), tlast_w[i], prev_last[i]);
`ifdef AXIS_BRAM_STREAMER_TUSER_EN
                        chk($sformatf("hold_user[%0d]", i), tuser_w[i], prev_user[i]);
`endif
                    end
                    if (tvalid_w[i] && tready) begin
                        chk($sformatf("word_expected[%0d]", i), exp_q[i].size() != 0, 1);
                        if (exp_q[i].size() != 0) begin
                            exp_t e;
                            e = exp_q[i].pop_front();
                            chk($sformatf("tdata[%0d]", i), tdata_w[i], e.data);
                            chk($sformatf("tlast[%0d]", i), tlast_w[i], e.last);
`ifdef AXIS_BRAM_STREAMER_TUSER_EN
                            chk($sformatf("tuser[%0d]", i), tuser_w[i], e.user);
`endif
                        end
                        xcyc[i][rcv[i] & 1023] = cyc;
                        rcv[i]++;
                    end
                    prev_stall[i] = tvalid_w[i] && !tready;
                    prev_data[i]  = tdata_w[i];
                    prev_last[i]  = tlast_w[i];
                    prev_user[i]  = tuser_w[i];
                end
            end
        end
    end

    // Model: the words a run must produce, pass by pass.
    task automatic push_exp(input int s, input int l, input int reps, input int max_words);
        int n = 0;
        for (int p = 0; p < reps; p++)
            for (int a = s; a <= l; a++) begin
                exp_t e;
                if (n >= max_words) return;
                e.data = bram_word(AW'(a));
                e.last = (a == l);
                e.user = (a == s);
                exp_q[0].push_back(e);
                exp_q[1].push_back(e);
                n++;
            end
    endtask

    task automatic go(input int s, input int l, input int reps);
        @(negedge aclk);
        cfg_start = AW'(s);
        cfg_last  = AW'(l);
        cfg_reps  = CW'(reps);
        cfg_enbl  = 1'b1;
    endtask

    task automatic wait_done(input int budget);
        bit d0 = 0, d1 = 0;
        int n = 0;
        while (!(d0 && d1) && n < budget) begin
            @(negedge aclk);
            if (sts_done_w[0]) d0 = 1;
            if (sts_done_w[1]) d1 = 1;
            n++;
        end
        chk("done_within_budget", {62'd0, d1, d0}, 3);
    endtask

    task automatic finish_run(input string tag);
        for (int i = 0; i < 2; i++)
            chk($sformatf("%s_all_words[%0d]", tag, i), exp_q[i].size(), 0);
        @(negedge aclk);
        cfg_enbl = 1'b0;
        repeat (3) @(negedge aclk);
        for (int i = 0; i < 2; i++)
            chk($sformatf("%s_back_idle[%0d]", tag, i), sts_done_w[i], 0);
    endtask

    initial begin
        int base [2];
        int n;
        repeat (3) @(negedge aclk);
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("rst_tvalid[%0d]", i), tvalid_w[i], 0);
            chk($sformatf("rst_tlast[%0d]", i), tlast_w[i], 0);
            chk($sformatf("rst_done[%0d]", i), sts_done_w[i], 0);
            chk($sformatf("rst_pass[%0d]", i), sts_pass_w[i], 0);
            chk($sformatf("rst_addr[%0d]", i), sts_addr_w[i], 0);
            chk($sformatf("rst_baddr[%0d]", i), baddr_w[i], 0);
            chk($sformatf("rst_brst[%0d]", i), brst_w[i], 1);
        end
        aresetn = 1'b1;
        ready_mode = 1;
        repeat (2) @(negedge aclk);

        // Single pass 4..7: literal latency and the model's shape pinned by hand.
        push_exp(4, 7, 1, 1000);
        chk("model_len", exp_q[0].size(), 4);
        chk("model_tail_last", exp_q[0][3].last, 1);
        chk("model_head_data", exp_q[0][0].data, 32'hA001_0004);
        for (int i = 0; i < 2; i++) base[i] = rcv[i];
        go(4, 7, 1);
        @(negedge aclk);
        @(negedge aclk); chk("lat1_before", tvalid_w[0], 0);
        @(negedge aclk); chk("lat1_rise", tvalid_w[0], 1); chk("lat1_data", tdata_w[0], 32'hA001_0004);
        @(negedge aclk); chk("lat3_before", tvalid_w[1], 0);
        @(negedge aclk); chk("lat3_rise", tvalid_w[1], 1); chk("lat3_data", tdata_w[1], 32'hA001_0004);
        wait_done(200);
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("t1_count[%0d]", i), rcv[i] - base[i], 4);
            chk($sformatf("t1_no_gap[%0d]", i), xcyc[i][(base[i] + 3) & 1023] - xcyc[i][base[i] & 1023], 3);
            chk($sformatf("t1_pass[%0d]", i), sts_pass_w[i], 1);
        end
        finish_run("t1");

        // Continuous 0..2: 20 words back to back across wraps, then stop.
        push_exp(0, 2, 40, 120);
        for (int i = 0; i < 2; i++) base[i] = rcv[i];
        go(0, 2, 0);
        n = 0;
        while ((rcv[0] - base[0] < 20 || rcv[1] - base[1] < 20) && n < 500) begin
            @(negedge aclk);
            n++;
        end
        chk("t2_reached_20", n < 500, 1);
        cfg_enbl = 1'b0;
        wait_done(200);
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("t2_no_gap[%0d]", i), xcyc[i][(base[i] + 19) & 1023] - xcyc[i][base[i] & 1023], 19);
            exp_q[i].delete();
        end
        finish_run("t2");

        // Two passes of 10..25 under random back-pressure.
        ready_mode = 2;
        push_exp(10, 25, 2, 1000);
        for (int i = 0; i < 2; i++) base[i] = rcv[i];
        go(10, 25, 2);
        wait_done(2000);
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("t3_count[%0d]", i), rcv[i] - base[i], 32);
            chk($sformatf("t3_pass[%0d]", i), sts_pass_w[i], 2);
        end
        finish_run("t3");

        // Enable held for exactly five issue cycles of a 100-word window.
        ready_mode = 1;
        push_exp(0, 99, 1, 5);
        for (int i = 0; i < 2; i++) base[i] = rcv[i];
        go(0, 99, 1);
        repeat (6) @(posedge aclk);
        @(negedge aclk);
        cfg_enbl = 1'b0;
        wait_done(200);
        for (int i = 0; i < 2; i++) chk($sformatf("t4_count[%0d]", i), rcv[i] - base[i], 5);
        finish_run("t4");

        // Empty window: straight to DONE.
        go(9, 3, 1);
        @(negedge aclk);
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("t5_done[%0d]", i), sts_done_w[i], 1);
            chk($sformatf("t5_novalid[%0d]", i), tvalid_w[i], 0);
            chk($sformatf("t5_addr[%0d]", i), sts_addr_w[i], 9);
        end
        finish_run("t5");

        // Reset with a full FIFO, then a fresh run.
        ready_mode = 0;
        go(0, 50, 1);
        repeat (15) @(negedge aclk);
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("t6_full_valid[%0d]", i), tvalid_w[i], 1);
            chk($sformatf("t6_head[%0d]", i), tdata_w[i], bram_word(AW'(0)));
        end
        aresetn  = 1'b0;
        cfg_enbl = 1'b0;
        @(negedge aclk);
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("t6_rst_valid[%0d]", i), tvalid_w[i], 0);
            chk($sformatf("t6_rst_addr[%0d]", i), baddr_w[i], 0);
            chk($sformatf("t6_we[%0d]", i), we_w[i], 0);
        end
        aresetn = 1'b1;
        ready_mode = 1;
        push_exp(5, 8, 1, 1000);
        for (int i = 0; i < 2; i++) base[i] = rcv[i];
        go(5, 8, 1);
        wait_done(200);
        for (int i = 0; i < 2; i++) chk($sformatf("t6_count[%0d]", i), rcv[i] - base[i], 4);
        finish_run("t6");

        // Random windows and repeat counts under random back-pressure.
        ready_mode = 2;
        for (int t = 0; t < 4; t++) begin
            int s, l, r;
            s = $urandom_range(0, 30);
            l = s + $urandom_range(0, 12);
            r = $urandom_range(1, 3);
            push_exp(s, l, r, 1000);
            for (int i = 0; i < 2; i++) base[i] = rcv[i];
            go(s, l, r);
            wait_done(3000);
            for (int i = 0; i < 2; i++) begin
                chk($sformatf("rnd_count[%0d]", i), rcv[i] - base[i], r * (l - s + 1));
                chk($sformatf("rnd_pass[%0d]", i), sts_pass_w[i], r);
            end
            finish_run("rnd");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/axis_bram_streamer.md
# axis_bram_streamer

Replays a configurable address window `[cfg_start, cfg_last]` of a BRAM onto an AXI4-Stream master, once, N times or continuously. It is the parametrised successor to the single-pass BRAM reader. It adds arbitrary start/stop addresses, a repeat count, a configurable BRAM read latency, and a small output FIFO so that back-pressure never loses or duplicates a word. It sits between a waveform/pattern BRAM (port A, read-only) and DAC or DMA stream consumers.

## Interface
Parameters:
- `AXIS_TDATA_WIDTH`, 32, stream width; `bram_porta_rddata` is zero-extended or LSB-truncated to fit.
- `BRAM_DATA_WIDTH`, 32, BRAM word width.
- `BRAM_ADDR_WIDTH`, 14, BRAM address width.
- `BRAM_LATENCY`, 1, aclk edges from address to valid rddata; legal values 1..3.
- `CNTR_WIDTH`, 16, width of the repeat and pass counters.

Ports:
- `aclk` in 1: clock.
- `aresetn` in 1: reset, synchronous, active-low.
- `cfg_enbl` in 1: run request, level.
- `cfg_start` in `BRAM_ADDR_WIDTH`: first address of the window.
- `cfg_last` in `BRAM_ADDR_WIDTH`: last address of the window, inclusive.
- `cfg_reps` in `CNTR_WIDTH`: number of passes; 0 means continuous.
- `sts_addr` out `BRAM_ADDR_WIDTH`: next address to issue.
- `sts_pass` out `CNTR_WIDTH`: completed passes.
- `sts_done` out 1: high in DONE.
- `m_axis_tready` in 1.
- `m_axis_tdata` out `AXIS_TDATA_WIDTH`.
- `m_axis_tvalid` out 1.
- `m_axis_tlast` out 1: marks the word read from `cfg_last`.
- `m_axis_tuser` out 1: only with `AXIS_BRAM_STREAMER_TUSER_EN`.
- `bram_porta_clk` out 1: equals `aclk`.
- `bram_porta_rst` out 1: equals `~aresetn`.
- `bram_porta_addr` out `BRAM_ADDR_WIDTH`.
- `bram_porta_rddata` in `BRAM_DATA_WIDTH`.
- `bram_porta_we` out 1: constant 0.

## Operation
State machine states: IDLE, RUN, DRAIN, DONE.
- **IDLE**: on `cfg_enbl`=1, latch `cfg_start`, `cfg_last`, `cfg_reps`. Set addr=`cfg_start` and pass=0.
  - If `cfg_start` > `cfg_last`, go to DONE with no output.
  - Otherwise go to RUN.
- **RUN**:
  - A read is issued in a cycle only if FIFO occupancy + in-flight reads < FIFO_DEPTH, where FIFO_DEPTH = `BRAM_LATENCY`+2. The issue is tagged with last = (addr == `cfg_last`). The tag travels in a `BRAM_LATENCY`-deep valid/last shift pipe and is written to the FIFO together with rddata.
  - Issue at `cfg_last`: pass increments.
    - If `cfg_reps`==0 or pass+1 < `cfg_reps`, addr wraps to `cfg_start`.
    - Otherwise go to DRAIN.
  - In all other issue cycles, addr increments by 1.
  - Wrap-around of the address space is never needed, because `cfg_last` ≤ max.
- **DRAIN**: no reads are issued. When the pipe and FIFO are empty, go to DONE.
- **DONE**: `sts_done`=1. When `cfg_enbl`=0, go to IDLE.
- `cfg_enbl`=0 during RUN: stop issuing immediately and go to DRAIN. Words already issued are still delivered; `tlast` is not forced. From DRAIN the block passes through DONE to IDLE, since enable is low.
- Changes to `cfg_*` while not in IDLE are ignored.
- pass counter saturates at all-ones in continuous mode; the address keeps wrapping.

## Timing
- Reset values: `m_axis_tvalid`=0, `m_axis_tlast`=0, `m_axis_tuser`=0, `sts_done`=0, `sts_pass`=0, `sts_addr`=0, `bram_porta_addr`=0. The FIFO and pipe are emptied and the state is IDLE. Reset mid-run discards all in-flight words.
- `bram_porta_addr` is driven from the address register. The address increments only on issue cycles.
- `cfg_enbl` sampled high at edge k gives the first issue in cycle k+1. `tvalid` rises after edge k+1+`BRAM_LATENCY`, so the first-word latency is `BRAM_LATENCY`+1 cycles.
- With `tready` held at 1, throughput is one word per cycle with no bubbles, including across pass wraps.
- AXIS rules:
  - A word transfers on `tvalid`&`tready`.
  - `tdata`, `tlast` and `tuser` are stable while `tvalid`=1 and `tready`=0.
  - `tvalid` never drops without a transfer, except on reset.
- Simultaneous FIFO push and pop at full occupancy is legal; occupancy is unchanged.

## Configuration
- `AXIS_BRAM_STREAMER_TUSER_EN` defined: `m_axis_tuser` port exists and is 1 on the word read from `cfg_start` at the start of every pass. It is carried through the pipe and FIFO the same way as `tlast`.
- Macro undefined: the port and its storage are absent. All other behaviour is identical.

## Test plan
- start=4, last=7, reps=1, `tready`=1, `BRAM_LATENCY`=1 → BRAM[4..7] on 4 consecutive cycles starting 2 cycles after enable; `tlast` on BRAM[7]; `sts_done`=1; `sts_pass`=1.
- start=0, last=2, reps=0, run 20 words → sequence 0,1,2,0,1,2… with no gaps; `tlast` on every 3rd word.
- `BRAM_LATENCY`=3, `tready` toggled with a random 50% pattern, start=10, last=25, reps=2 → exactly 32 words in order with no loss or duplication; `tdata` is stable while stalled.
- `cfg_enbl` dropped after 5 issues of a 100-word window → exactly the issued words delivered; no `tlast`; `sts_done` pulses, then the block returns to IDLE.
- start=9, last=3 → no `tvalid` ever; `sts_done`=1 the cycle after enable.
- `aresetn` asserted with a full FIFO and `tready`=0 → `tvalid`=0 the next cycle; after release and re-enable, the stream restarts at `cfg_start`.
